// File: rtl/feature_point_fetch.sv
// feature_point_fetch: reads the 12 rect-corner integral-image words of one Haar feature
// descriptor and streams them as points 0..11 to the rectangle-sum stage.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   feat_val_i / feat_ready_o    descriptor handshake (ready only while idle)
//   feat_rect_i                  {r2,r1,r0}, each {x,y,w,h}, r0 at LSBs
//   feat_three_i                 rect 2 present
//   feat_weight_i / weight_o     weights, latched on accept
//   win_x_i, win_y_i             window base column/row
//   ii_rd_en_o, ii_rd_addr_o     II memory read request
//   ii_rd_data_i                 II memory data, MEM_LAT cycles after the request
//   ii_val_o, num_point_o        point valid and index {rect,corner}
//   ii_data_o                    point data, one cycle after its index
module feature_point_fetch #(
   parameter int IMG_W      = 321,
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 32,
   parameter int COORD_W    = 5,
   parameter int MEM_LAT    = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   feat_val_i,
   output logic                   feat_ready_o,
   input  logic [12*COORD_W-1:0]  feat_rect_i,
   input  logic                   feat_three_i,
   input  logic [3:0]             feat_weight_i,
   input  logic [ADDR_W-1:0]      win_x_i,
   input  logic [ADDR_W-1:0]      win_y_i,
   output logic                   ii_rd_en_o,
   output logic [ADDR_W-1:0]      ii_rd_addr_o,
   input  logic [DATA_W-1:0]      ii_rd_data_i,
   output logic                   ii_val_o,
   output logic [3:0]             num_point_o,
   output logic [DATA_W-1:0]      ii_data_o,
   output logic [3:0]             weight_o
);
   localparam int RW     = 4*COORD_W;
   localparam int WAIT_N = MEM_LAT+1+GAP_CYCLES;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t                    r_state;
   logic [3:0]                r_k;
   logic [7:0]                r_wcnt;
   logic [3*RW-1:0]           r_rect;
   logic                      r_three;
   logic [ADDR_W-1:0]         r_wx, r_wy;
   logic                      r_ready;
   logic [3:0]                r_weight;
   logic                      r_rd_en;
   logic [ADDR_W-1:0]         r_addr;
   logic                      r_iv, r_iz;
   logic [3:0]                r_ik;
   logic [MEM_LAT-1:0]        r_tv, r_tz;
   logic [MEM_LAT-1:0][3:0]   r_tk;
   logic [DATA_W-1:0]         r_data;
   logic [RW-1:0]             w_rect;
   logic [ADDR_W-1:0]         w_cx, w_cy, w_row, w_addr;
   logic                      w_fz, w_acc;
   // Corner of point k: rect = k[3:2], corner = k[1:0]; corners 1,2 add w, corners 2,3 add h.
   assign w_rect = r_k[3] ? r_rect[3*RW-1:2*RW] : r_k[2] ? r_rect[2*RW-1:RW] : r_rect[RW-1:0];
   assign w_cx   = ADDR_W'(w_rect[4*COORD_W-1:3*COORD_W])
                 + ((r_k[1] ^ r_k[0]) ? ADDR_W'(w_rect[2*COORD_W-1:COORD_W]) : '0);
   assign w_cy   = ADDR_W'(w_rect[3*COORD_W-1:2*COORD_W])
                 + (r_k[1] ? ADDR_W'(w_rect[COORD_W-1:0]) : '0);
   assign w_row  = r_wy + w_cy;
   assign w_addr = ADDR_W'(w_row * ADDR_W'(IMG_W)) + r_wx + w_cx;
   assign w_fz   = r_k[3] & ~r_three;
   assign w_acc  = feat_val_i & r_ready;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_k      <= '0;
         r_wcnt   <= '0;
         r_rect   <= '0;
         r_three  <= 1'b0;
         r_wx     <= '0;
         r_wy     <= '0;
         r_ready  <= 1'b0;
         r_weight <= '0;
         r_rd_en  <= 1'b0;
         r_addr   <= '0;
         r_iv     <= 1'b0;
         r_ik     <= '0;
         r_iz     <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_addr  <= '0;
         r_iv    <= 1'b0;
         r_ik    <= '0;
         r_iz    <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ready <= ~w_acc;
               if (w_acc) begin
                  r_state  <= ISSUE;
                  r_k      <= '0;
                  r_rect   <= feat_rect_i;
                  r_three  <= feat_three_i;
                  r_wx     <= win_x_i;
                  r_wy     <= win_y_i;
                  r_weight <= feat_weight_i;
               end
            end
            ISSUE: begin
               r_iv    <= 1'b1;
               r_ik    <= r_k;
               r_iz    <= w_fz;
               r_rd_en <= ~w_fz;
               r_addr  <= w_fz ? '0 : w_addr;
               r_k     <= r_k + 4'd1;
               if (r_k == 4'd11) begin
                  r_state <= WAIT;
                  r_wcnt  <= '0;
               end
            end
            default: begin
               r_wcnt <= r_wcnt + 8'd1;
               if (r_wcnt == 8'(WAIT_N-1)) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end
            end
         endcase
      end
   end
   // Tags ride alongside the memory latency so each point's index lines up with its returning word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tv   <= '0;
         r_tz   <= '0;
         r_tk   <= '0;
         r_data <= '0;
      end else begin
         r_tv   <= MEM_LAT'({r_tv, r_iv});
         r_tz   <= MEM_LAT'({r_tz, r_iz});
         r_tk   <= (4*MEM_LAT)'({r_tk, r_ik});
         r_data <= (r_tv[MEM_LAT-1] & ~r_tz[MEM_LAT-1]) ? ii_rd_data_i : '0;
      end
   end
   assign feat_ready_o = r_ready;
   assign weight_o     = r_weight;
   assign ii_rd_en_o   = r_rd_en;
   assign ii_rd_addr_o = r_addr;
   assign ii_val_o     = r_tv[MEM_LAT-1];
   assign num_point_o  = r_tk[MEM_LAT-1];
   assign ii_data_o    = r_data;
endmodule
